uart_rx_monitor: RTL and testbench
==================================

Name: uart_rx_monitor

Overview:
- Serial receive stage directly downstream of the SoC `uart_tx` pin in the simulation/FPGA fixture.
- Oversamples the line and decodes 8N1 frames, LSB first.
- Buffers received bytes in a first-word-fall-through FIFO with a valid/ready output.
- Consumers are a testbench console printer or a host bridge. The block reports framing errors and FIFO overflow.

Parameters:
- BaudDiv, 868, clock cycles per bit (100 MHz / 115200); legal range is 4 or more.
- FifoDepth, 8, FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-high
- uart_rx_i  in  1  serial line, connected to the SoC `uart_tx`; idle high
- clear_i  in  1  synchronous: flushes the FIFO and clears `overflow_o`
- data_o  out  8  FIFO head byte
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  pop when valid_o and ready_i are both 1
- fifo_count_o  out  $clog2(FifoDepth)+1  current occupancy
- frame_err_o  out  1  one-cycle pulse when the stop bit samples 0
- parity_err_o  out  1  one-cycle pulse on parity mismatch (see Optional Feature)
- overflow_o  out  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset values:
  - All outputs are 0; data_o = 0x00; fifo_count_o = 0.
  - Synchronizer flops reset to 1 (line idle).
  - FSM resets to IDLE; baud counter and bit counter reset to 0.
- Input synchronizer: uart_rx_i passes through a 2-flop synchronizer. All decoding uses the synchronized value `rx_s`. This adds 2 cycles of pin-to-detect delay.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - IDLE: on `rx_s`==0, load the baud counter with BaudDiv/2-1 (integer divide) and go to START.
  - START: when the counter reaches 0, sample. If `rx_s`==1 it is a glitch: return to IDLE with no output. Otherwise reload BaudDiv-1, clear the bit index, and go to DATA.
  - DATA: at each counter expiry, shift `rx_s` into bit[index], LSB first, then reload BaudDiv-1. After bit 7, go to STOP (or to PARITY when the feature is enabled).
  - STOP: at counter expiry, sample.
    - `rx_s`==1: push the byte and go to IDLE.
    - `rx_s`==0: pulse frame_err_o, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`==1, then go to IDLE. A break condition produces exactly one frame_err_o pulse.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE is entered in the cycle after the stop sample.
- Latency: the pushed byte appears on data_o with valid_o=1 in the cycle after the stop-bit sample, provided the FIFO was empty.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - Full when the pointer MSBs differ and the remaining bits are equal. Empty when the pointers are equal.
  - data_o holds mem[rd_ptr] while valid_o=1, and must stay stable until the pop.
- Push and pop in the same cycle:
  - Both are performed and the count is unchanged.
  - When full, a simultaneous pop frees a slot, so the push is accepted.
- Push while full without a pop: the byte is dropped and overflow_o is set. It stays set until clear_i or reset.
- Pop while empty: ignored.
- clear_i:
  - Pointers go to 0 and overflow_o goes to 0 in the next cycle.
  - A push in the same cycle is discarded.
  - The FSM is unaffected; a frame in progress completes normally.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the FSM waits in IDLE for the next falling edge. If the line is already low, the partial frame resumes from START, which is acceptable. Any resulting framing error is reported normally.
- Counter width: $clog2(BaudDiv). Counters count down and never wrap past 0.

Optional Feature:
- Macro: UART_RX_MONITOR_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples one bit, even parity.
  - If the XOR of the 8 data bits and the parity bit is 1, parity_err_o pulses for one cycle in the STOP-sample cycle and the byte is discarded. The stop bit is still checked, and frame_err_o takes precedence only in that it also pulses.
- Not defined: no PARITY state, parity_err_o is tied to 0, and the frame is 8N1.

Test Plan:
- BaudDiv=8, FifoDepth=4: send 0x55 then 0xA3 back-to-back → data_o=0x55 with valid_o=1 one cycle after the stop sample, then 0xA3; fifo_count_o=2 with ready_i=0.
- Low pulse of 3 cycles (shorter than BaudDiv/2) on an idle line → no push, no error pulse, FSM back in IDLE.
- Frame 0x3C with stop bit=0, line held low for 40 cycles, then 0x7E sent → exactly one frame_err_o pulse, 0x3C not pushed, 0x7E received.
- Send 5 bytes 0x01–0x05 with ready_i=0 → FIFO holds 0x01–0x04 and overflow_o=1. Pop all → 0x01..0x04 in order. Pulse clear_i → overflow_o=0.
- FIFO full, ready_i=1 held during the stop sample of 0x06 → pop and push both occur, fifo_count_o stays 4, 0x06 is at the tail, overflow_o stays 0.
- With UART_RX_MONITOR_PARITY_EN, send 0x07 with parity bit 0 → parity_err_o pulses and there is no push. Resend with parity bit 1 → 0x07 is received.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// Oversampling 8N1 UART receiver feeding a first-word-fall-through FIFO with valid/ready pop.
// Define UART_RX_MONITOR_PARITY_EN to add an even-parity bit between the data and the stop bit.
module uart_rx_monitor #(
  parameter int BaudDiv   = 868,
  parameter int FifoDepth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         uart_rx_i,
  input  logic                         clear_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(FifoDepth):0]   fifo_count_o,
  output logic                         frame_err_o,
  output logic                         parity_err_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(BaudDiv);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [CW-1:0] HALF  = CW'(BaudDiv/2 - 1);
  localparam logic [CW-1:0] FULLC = CW'(BaudDiv - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic          rx_meta, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          push;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MONITOR_PARITY_EN
  logic par_bit, par_err_q;
  assign par_bad      = ^{shreg, par_bit};
  assign parity_err_o = par_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_bit     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
`ifdef UART_RX_MONITOR_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state)
        IDLE: if (!rx_s) begin
          cnt   <= HALF;
          state <= START;
        end
        START: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else if (rx_s) state <= IDLE;   // line bounced back high: glitch, not a start bit
          else begin
            cnt     <= FULLC;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            shreg[bit_idx] <= rx_s;
            cnt            <= FULLC;
            bit_idx        <= bit_idx + 3'd1;
`ifdef UART_RX_MONITOR_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_MONITOR_PARITY_EN
        PARITY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            par_bit <= rx_s;
            cnt     <= FULLC;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
`ifdef UART_RX_MONITOR_PARITY_EN
            par_err_q <= par_bad;
`endif
            if (rx_s) state <= IDLE;
            else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Push straight from the stop sample so an empty FIFO shows the byte on the next cycle.
  assign push = (state == STOP) && (cnt == '0) && rx_s && !par_bad;

  logic [7:0]  mem [FifoDepth];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid_o      = !empty;
  assign pop          = valid_o && ready_i;
  assign wr_en        = push && (!full || pop);
  assign data_o       = valid_o ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign fifo_count_o = wr_ptr - rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (push && full && !pop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !clear_i) mem[wr_ptr[AW-1:0]] <= shreg;
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized bench for uart_rx_monitor: serial frames driven bit by bit, FIFO contents and error
// pulses checked against a queue model of the receiver's expected output.
module tb_uart_rx_monitor;
  localparam int B = 8;
  localparam int D = 4;
  localparam int H = B/2 - 1;

  logic       clk_i = 0, rst_i = 0, uart_rx_i = 1, clear_i = 0, ready_i = 0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overflow_o;
  logic [$clog2(D):0] fifo_count_o;

  uart_rx_monitor #(.BaudDiv(B), .FifoDepth(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i), .clear_i(clear_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .fifo_count_o(fifo_count_o),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_chk, n_err;
  int         fe_cnt, pe_cnt, exp_fe, exp_pe;
  logic [7:0] q[$];
  bit         m_ovf;

  always @(negedge clk_i) begin
    if (frame_err_o)  fe_cnt++;
    if (parity_err_o) pe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (B) begin @(posedge clk_i); #1; end
  endtask

  // One frame; the model records what the receiver should deliver once the frame is over.
  task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                      input int hold_low, input int gap);
    uart_rx_i = 0; bit_wait();
    for (int i = 0; i < 8; i++) begin uart_rx_i = d[i]; bit_wait(); end
`ifdef UART_RX_MONITOR_PARITY_EN
    uart_rx_i = (^d) ^ !par_ok; bit_wait();
`endif
    uart_rx_i = stop_ok; bit_wait();
    if (!stop_ok) repeat (hold_low) begin @(posedge clk_i); #1; end
    uart_rx_i = 1;
    if (!stop_ok) exp_fe++;
    if (!par_ok) exp_pe++;
    if (stop_ok && par_ok) begin
      if (q.size() < D) q.push_back(d);
      else m_ovf = 1;
    end
    repeat (gap) begin @(posedge clk_i); #1; end
  endtask

  task automatic pop_one();
    logic [7:0] e;
    e = q.pop_front();
    chk("pop_valid", valid_o, 1);
    chk("pop_data", data_o, e);
    ready_i = 1; @(posedge clk_i); #1; ready_i = 0;
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
    chk("drain_cnt", fifo_count_o, 0);
  endtask

  initial begin
    #1 rst_i = 1;
    repeat (3) @(negedge clk_i);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_cnt", fifo_count_o, 0);
    chk("rst_fe", frame_err_o, 0);
    chk("rst_pe", parity_err_o, 0);
    chk("rst_ovf", overflow_o, 0);
    @(posedge clk_i); #1 rst_i = 0;
    repeat (5) begin @(posedge clk_i); #1; end

    // back-to-back 0x55, 0xA3 with exact first-byte latency
    fork
      send(8'h55, 1, 1, 0, 0);
      begin
        repeat (3 + H + 9*B) @(posedge clk_i);
`ifdef UART_RX_MONITOR_PARITY_EN
        repeat (B) @(posedge clk_i);
`endif
        @(negedge clk_i); chk("lat_pre", valid_o, 0);
        @(negedge clk_i); chk("lat_valid", valid_o, 1);
        chk("lat_data", data_o, 8'h55);
      end
    join
    send(8'hA3, 1, 1, 0, 4);
    chk("b2b_cnt", fifo_count_o, 2);
    drain();

    // short low glitch must be ignored
    uart_rx_i = 0; repeat (3) begin @(posedge clk_i); #1; end
    uart_rx_i = 1; repeat (20) begin @(posedge clk_i); #1; end
    chk("glitch_cnt", fifo_count_o, 0);
    chk("glitch_fe", fe_cnt, exp_fe);
    send(8'($urandom), 1, 1, 0, 4);
    drain();

    // break after bad stop bit, then a good frame
    send(8'h3C, 0, 1, 40, 4);
    send(8'h7E, 1, 1, 0, 4);
    chk("brk_fe", fe_cnt, exp_fe);
    chk("brk_cnt", fifo_count_o, 1);
    drain();

    // overflow and clear
    for (int i = 1; i <= 5; i++) send(8'(i), 1, 1, 0, 2);
    chk("ovf_cnt", fifo_count_o, 4);
    chk("ovf_flag", overflow_o, 1);
    drain();
    chk("ovf_sticky", overflow_o, 1);
    clear_i = 1; @(posedge clk_i); #1 clear_i = 0; m_ovf = 0;
    chk("clr_ovf", overflow_o, 0);

    // push and pop in the same cycle while full
    for (int i = 0; i < D; i++) send(8'($urandom), 1, 1, 0, 2);
    chk("full_cnt", fifo_count_o, D);
    fork
      send(8'h06, 1, 1, 0, 2);
      begin
        repeat (3 + H + 9*B) @(posedge clk_i);
`ifdef UART_RX_MONITOR_PARITY_EN
        repeat (B) @(posedge clk_i);
`endif
        #1 ready_i = 1;
        @(posedge clk_i); #1 ready_i = 0;
        void'(q.pop_front());
      end
    join
    chk("pp_cnt", fifo_count_o, D);
    chk("pp_ovf", overflow_o, 0);
    chk("pp_tail", q[D-1], 8'h06);
    drain();

`ifdef UART_RX_MONITOR_PARITY_EN
    send(8'h07, 1, 0, 0, 4);
    chk("par_bad_cnt", fifo_count_o, 0);
    chk("par_pe", pe_cnt, exp_pe);
    send(8'h07, 1, 1, 0, 4);
    drain();
`endif

    // random mix of good and broken frames with occasional draining
    for (int n = 0; n < 10; n++) begin
      bit ok;
      ok = ($urandom % 4) != 0;
      send(8'($urandom), ok, 1, ok ? 0 : int'($urandom_range(5, 30)), 3);
      if ($urandom % 3 == 0) drain();
    end
    chk("rnd_cnt", fifo_count_o, q.size());
    chk("rnd_ovf", overflow_o, m_ovf);
    drain();

    chk("end_fe", fe_cnt, exp_fe);
    chk("end_pe", pe_cnt, exp_pe);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
